baccarat_sched: RTL and testbench

BACCARAT_SCHED -- requirements
Module: baccarat_sched

---
 rtl/baccarat_pkg.sv | 43 ++++
 rtl/bac_banker_rule.sv | 35 +++
 rtl/baccarat_sched.sv | 147 ++++++++++++++
 tb/tb_baccarat_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared definitions for the baccarat deal scheduler:
//   state_t         - scheduler state encoding (also exported on state_dbg)
//   SCORE_NATURAL   - two-card score that ends the round immediately
//   PLAYER_DRAW_MAX - highest score at which the player (or a banker facing a
//                     standing player) draws a third card
//   LD_*            - bit positions of the load strobes in the strobe vector
//   card_value()    - maps a card rank 1-13 to its baccarat value 0-9
// -----------------------------------------------------------------------------
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1  = 4'd0,
    DEAL_D1  = 4'd1,
    DEAL_P2  = 4'd2,
    DEAL_D2  = 4'd3,
    SETTLE2  = 4'd4,
    DECIDE_P = 4'd5,
    DEAL_P3  = 4'd6,
    SETTLE3  = 4'd7,
    DECIDE_D = 4'd8,
    DEAL_D3  = 4'd9,
    SETTLE4  = 4'd10,
    DONE     = 4'd11
  } state_t;

  localparam logic [3:0] SCORE_NATURAL   = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  localparam int LD_P1 = 0;
  localparam int LD_P2 = 1;
  localparam int LD_P3 = 2;
  localparam int LD_D1 = 3;
  localparam int LD_D2 = 4;
  localparam int LD_D3 = 5;

  // Ten and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

endpackage

// File: rtl/bac_banker_rule.sv
// -----------------------------------------------------------------------------
// bac_banker_rule
// Combinational banker third-card decision.
// Ports:
//   dscore       in  4  banker two-card score 0-9
//   v            in  4  value 0-9 of the player's third card
//   player_stood in  1  player kept two cards (v is then irrelevant)
//   draw         out 1  banker takes a third card
// -----------------------------------------------------------------------------
module bac_banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  input  logic       player_stood,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    if (player_stood) begin
      draw = (dscore <= PLAYER_DRAW_MAX);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (v != 4'd8);
        4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
        4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
        4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_sched.sv
// -----------------------------------------------------------------------------
// baccarat_sched
// Step-driven scheduler for one baccarat round: deals two cards each to player
// and dealer, applies the natural / player / banker third-card rules and
// reports the winner.
// Parameter:
//   STEP_ACTIVE_LOW  1: step asserted when low (push-button), 0: when high
// Ports:
//   slow_clock   in  1  sole clock
//   reset        in  1  synchronous active-high reset
//   step         in  1  raw button level, one deal step per press
//   pscore       in  4  player hand score 0-9
//   dscore       in  4  dealer hand score 0-9
//   pcard3       in  4  player third-card rank 1-13
//   load_pcard1/2/3, load_dcard1/2/3  out 1  one-cycle card load strobes
//   player_win, dealer_win            out 1  result, both high on a tie
//   round_done   out 1  high while in DONE
//   state_dbg    out 4  current state encoding
// Build option:
//   BACCARAT_AUTO_STEP_EN  when defined, DEAL states advance every cycle and
//                          step is ignored.
// -----------------------------------------------------------------------------
module baccarat_sched
  import baccarat_pkg::*;
#(
  parameter bit STEP_ACTIVE_LOW = 1'b1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       round_done,
  output logic [3:0] state_dbg
);

`ifdef BACCARAT_AUTO_STEP_EN
  localparam bit AUTO_STEP = 1'b1;
`else
  localparam bit AUTO_STEP = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [5:0] strobe_q, strobe_d;
  logic       player_win_q, player_win_d;
  logic       dealer_win_q, dealer_win_d;
  logic       stood_q, stood_d;
  logic       step_prev_q, step_prev_d;

  logic       step_act;
  logic       press;
  logic [3:0] v;
  logic       banker_draw;

  assign step_act = STEP_ACTIVE_LOW ? ~step : step;
  // Rising edge of the asserted level; a held button counts once.
  assign press    = AUTO_STEP | (step_act & ~step_prev_q);
  assign v        = card_value(pcard3);

  bac_banker_rule u_banker (
    .dscore       (dscore),
    .v            (v),
    .player_stood (stood_q),
    .draw         (banker_draw)
  );

  always_comb begin
    state_d      = state_q;
    strobe_d     = '0;
    stood_d      = stood_q;
    player_win_d = player_win_q;
    dealer_win_d = dealer_win_q;
    step_prev_d  = step_act;

    case (state_q)
      DEAL_P1: if (press) begin strobe_d[LD_P1] = 1'b1; state_d = DEAL_D1; end
      DEAL_D1: if (press) begin strobe_d[LD_D1] = 1'b1; state_d = DEAL_P2; end
      DEAL_P2: if (press) begin strobe_d[LD_P2] = 1'b1; state_d = DEAL_D2; end
      DEAL_D2: if (press) begin strobe_d[LD_D2] = 1'b1; state_d = SETTLE2; end
      SETTLE2: begin
        if ((pscore >= SCORE_NATURAL) || (dscore >= SCORE_NATURAL)) state_d = DONE;
        else                                                        state_d = DECIDE_P;
      end
      DECIDE_P: begin
        if (pscore <= PLAYER_DRAW_MAX) begin
          state_d = DEAL_P3;
        end else begin
          stood_d = 1'b1;
          state_d = DECIDE_D;
        end
      end
      DEAL_P3: if (press) begin strobe_d[LD_P3] = 1'b1; state_d = SETTLE3; end
      SETTLE3:  state_d = DECIDE_D;
      DECIDE_D: state_d = banker_draw ? DEAL_D3 : DONE;
      DEAL_D3: if (press) begin strobe_d[LD_D3] = 1'b1; state_d = SETTLE4; end
      SETTLE4:  state_d = DONE;
      DONE:     state_d = DONE;
      default:  state_d = DEAL_P1;
    endcase

    // Results are latched once, on the edge that enters DONE, then held.
    if ((state_d == DONE) && (state_q != DONE)) begin
      player_win_d = (pscore >= dscore);
      dealer_win_d = (dscore >= pscore);
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q      <= DEAL_P1;
      strobe_q     <= '0;
      stood_q      <= 1'b0;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
      // Seed history with the live level so a held button is not a press.
      step_prev_q  <= step_act;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      stood_q      <= stood_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
      step_prev_q  <= step_prev_d;
    end
  end

  assign load_pcard1 = strobe_q[LD_P1];
  assign load_pcard2 = strobe_q[LD_P2];
  assign load_pcard3 = strobe_q[LD_P3];
  assign load_dcard1 = strobe_q[LD_D1];
  assign load_dcard2 = strobe_q[LD_D2];
  assign load_dcard3 = strobe_q[LD_D3];
  assign player_win  = player_win_q;
  assign dealer_win  = dealer_win_q;
  assign round_done  = (state_q == DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_baccarat_sched.sv
module tb_baccarat_sched;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win, dealer_win, round_done;
  logic [3:0] state_dbg;
  logic [5:0] strb;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cnt[6];
  int         multi = 0;
  logic [17:0] seq_code = '0;

  always #5 slow_clock = ~slow_clock;

  baccarat_sched #(.STEP_ACTIVE_LOW(1'b1)) dut (
    .slow_clock  (slow_clock),
    .reset       (reset),
    .step        (step),
    .pscore      (pscore),
    .dscore      (dscore),
    .pcard3      (pcard3),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .player_win  (player_win),
    .dealer_win  (dealer_win),
    .round_done  (round_done),
    .state_dbg   (state_dbg)
  );

  // bit order: 0 p1, 1 p2, 2 p3, 3 d1, 4 d2, 5 d3
  assign strb = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

  // Strobe log: per-strobe counts and the order as a string of 3-bit codes.
  always @(posedge slow_clock) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) cnt[i] = 0;
      multi    = 0;
      seq_code = '0;
    end else begin
      if ($countones(strb) > 1) multi++;
      for (int i = 0; i < 6; i++) begin
        if (strb[i]) begin
          cnt[i]++;
          seq_code = {seq_code[14:0], 3'(i)};
        end
      end
    end
  end

  function automatic int total();
    int s = 0;
    for (int i = 0; i < 6; i++) s += cnt[i];
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge slow_clock);
  endtask

  task automatic press();
    step = 1'b0;
    tick(1);
    step = 1'b1;
    tick(1);
  endtask

  task automatic press_chk(input string tag, input logic [5:0] mask, input logic [3:0] st);
    step = 1'b0;
    tick(1);
    check({tag, "_strobe"}, strb, mask);
    check({tag, "_state"}, state_dbg, st);
    step = 1'b1;
    tick(1);
    check({tag, "_strobe_off"}, strb, 6'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, state_dbg, 4'd0);
    check({tag, "_strb"}, strb, 6'b0);
    check({tag, "_pwin"}, player_win, 1'b0);
    check({tag, "_dwin"}, dealer_win, 1'b0);
    check({tag, "_done"}, round_done, 1'b0);
  endtask

  initial begin
    tick(2);
`ifdef BACCARAT_AUTO_STEP_EN
    // Auto mode: all-zero scores, full six-card round, tie.
    check_reset_state("auto_rst");
    reset = 1'b0;
    tick(14);
    check("auto_state", state_dbg, 4'd11);
    check("auto_done", round_done, 1'b1);
    check("auto_pwin", player_win, 1'b1);
    check("auto_dwin", dealer_win, 1'b1);
    check("auto_order", seq_code, 18'o031425);
    check("auto_total", total(), 6);
    check("auto_multi", multi, 0);
`else
    // Natural: p=8, d=3.
    pscore = 4'd8; dscore = 4'd3;
    check_reset_state("rst");
    reset = 1'b0;
    press_chk("p1", 6'b000001, 4'd1);
    press_chk("d1", 6'b001000, 4'd2);
    press_chk("p2", 6'b000010, 4'd3);
    press_chk("d2", 6'b010000, 4'd4);
    check("nat_state", state_dbg, 4'd11);
    check("nat_pwin", player_win, 1'b1);
    check("nat_dwin", dealer_win, 1'b0);
    check("nat_done", round_done, 1'b1);
    check("nat_order", seq_code, 18'o0314);
    press();
    check("done_ignore_state", state_dbg, 4'd11);
    check("done_ignore_total", total(), 4);

    // Player draws 7, banker on 6 draws.
    do_reset();
    pscore = 4'd4; dscore = 4'd6; pcard3 = 4'd7;
    repeat (4) press();
    check("t2_decide_p", state_dbg, 4'd5);
    tick(1);
    check("t2_deal_p3", state_dbg, 4'd6);
    press_chk("p3", 6'b000100, 4'd7);
    check("t2_decide_d", state_dbg, 4'd8);
    tick(1);
    check("t2_deal_d3", state_dbg, 4'd9);
    press_chk("d3", 6'b100000, 4'd10);
    check("t2_state", state_dbg, 4'd11);
    check("t2_pwin", player_win, 1'b0);
    check("t2_dwin", dealer_win, 1'b1);
    check("t2_order", seq_code, 18'o031425);

    // 7 vs 7: both stand, tie; a press during DECIDE is ignored.
    do_reset();
    pscore = 4'd7; dscore = 4'd7;
    repeat (4) press();
    check("t3_decide_p", state_dbg, 4'd5);
    step = 1'b0;
    tick(1);
    check("t3_decide_d", state_dbg, 4'd8);
    tick(1);
    check("t3_state", state_dbg, 4'd11);
    step = 1'b1;
    tick(1);
    check("t3_pwin", player_win, 1'b1);
    check("t3_dwin", dealer_win, 1'b1);
    check("t3_p3_cnt", cnt[2], 0);
    check("t3_d3_cnt", cnt[5], 0);

    // pcard3=12 (v=0), banker on 3 draws.
    do_reset();
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd12;
    repeat (4) press();
    tick(1);
    press();
    tick(1);
    check("t4a_draw", state_dbg, 4'd9);

    // pcard3=8, banker on 3 stands.
    do_reset();
    pcard3 = 4'd8;
    repeat (4) press();
    tick(1);
    press();
    tick(1);
    check("t4b_state", state_dbg, 4'd11);
    check("t4b_d3_cnt", cnt[5], 0);
    check("t4b_pwin", player_win, 1'b1);
    check("t4b_dwin", dealer_win, 1'b0);

    // Held step: one strobe only.
    do_reset();
    pscore = 4'd4; dscore = 4'd6; pcard3 = 4'd7;
    step = 1'b0;
    tick(20);
    check("hold_p1_cnt", cnt[0], 1);
    check("hold_total", total(), 1);
    check("hold_state", state_dbg, 4'd1);
    step = 1'b1;
    tick(1);
    repeat (3) press();
    tick(1);
    check("t5_deal_p3", state_dbg, 4'd6);
    // Reset in DEAL_P3 with the button held through release.
    step = 1'b0;
    reset = 1'b1;
    tick(1);
    check_reset_state("mid_rst");
    reset = 1'b0;
    tick(3);
    check("post_rst_state", state_dbg, 4'd0);
    check("post_rst_total", total(), 0);
    step = 1'b1;
    tick(1);
    check("multi", multi, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
